// File: rtl/serial_priority_encoder.sv
// Serial priority encoder: takes an N-bit request vector over valid/ready
// and emits the index of each set bit, one beat at a time.
module serial_priority_encoder #(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       st, st_n;
  logic [N-1:0] pend, pend_n;
  logic         zflag, zflag_n;
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] sel;
  logic [W-1:0] ptr_inc;
  logic         onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      pend  <= '0;
      zflag <= 1'b0;
      ptr   <= '0;
    end else begin
      st    <= st_n;
      pend  <= pend_n;
      zflag <= zflag_n;
      ptr   <= ptr_n;
    end
  end

  // Later matches overwrite earlier ones, so loop order sets priority.
  always_comb begin
    int j;
    sel = '0;
    j   = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++)
        if (pend[W'(i)]) sel = W'(i);
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--)
        if (pend[W'(i)]) sel = W'(i);
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (pend[W'(j)]) sel = W'(j);
      end
    end
  end

  assign onehot  = (pend != '0) &&
                   ((pend & (pend - N'(1))) == '0);
  assign ptr_inc = (sel == W'(N - 1)) ? '0 : sel + W'(1);

  assign out_valid = (st == EMIT);
  assign in_ready  = (st == IDLE);
  assign out_last  = onehot | zflag;
  assign out_none  = zflag;
  assign out_idx   = zflag ? '0 : sel;

  always_comb begin
    st_n    = st;
    pend_n  = pend;
    zflag_n = zflag;
    ptr_n   = ptr;
    unique case (st)
      IDLE: begin
        if (in_valid) begin
          st_n = EMIT;
          if (in_vec == '0) zflag_n = 1'b1;
          else              pend_n  = in_vec;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_n = pend & ~(N'(1) << sel);
          if (MODE == 2 && !zflag) ptr_n = ptr_inc;
          if (out_last) begin
            pend_n  = '0;
            zflag_n = 1'b0;
            st_n    = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_serial_priority_encoder.sv
// Directed bench for serial_priority_encoder: MODE0/1/2 at N=8
// sharing one stimulus, plus a MODE2 N=6 instance.
module tb_serial_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_vec = '0;
  logic       ov [3];
  logic       ir [3];
  logic       lst [3];
  logic       non [3];
  logic [2:0] idx [3];

  logic       in_valid6 = 1'b0;
  logic [5:0] in_vec6 = '0;
  logic       ov6, ir6, lst6, non6;
  logic [2:0] idx6;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_priority_encoder #(.N(8), .MODE(0)) m0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_vec(in_vec),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_idx(idx[0]), .out_last(lst[0]),
    .out_none(non[0])
  );

  serial_priority_encoder #(.N(8), .MODE(1)) m1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_vec(in_vec),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_idx(idx[1]), .out_last(lst[1]),
    .out_none(non[1])
  );

  serial_priority_encoder #(.N(8), .MODE(2)) m2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(ir[2]),
    .in_vec(in_vec),
    .out_valid(ov[2]), .out_ready(out_ready),
    .out_idx(idx[2]), .out_last(lst[2]),
    .out_none(non[2])
  );

  serial_priority_encoder #(.N(6), .MODE(2)) m6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(ir6),
    .in_vec(in_vec6),
    .out_valid(ov6), .out_ready(out_ready),
    .out_idx(idx6), .out_last(lst6),
    .out_none(non6)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] v);
    for (int t = 0; t < 20 && !ir[0]; t++) step();
    if (!ir[0]) chk("accept_timeout", ir[0], 1'b1);
    in_valid = 1'b1;
    in_vec   = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic accept6(input logic [5:0] v);
    for (int t = 0; t < 20 && !ir6; t++) step();
    if (!ir6) chk("accept6_timeout", ir6, 1'b1);
    in_valid6 = 1'b1;
    in_vec6   = v;
    step();
    in_valid6 = 1'b0;
  endtask

  task automatic beat(input int m,
                      input logic [2:0] e_idx,
                      input logic e_last,
                      input string tag);
    chk({tag, "_valid"}, ov[m], 1'b1);
    chk({tag, "_idx"}, idx[m], e_idx);
    chk({tag, "_last"}, lst[m], e_last);
    chk({tag, "_none"}, non[m], 1'b0);
  endtask

  task automatic beat6(input logic [2:0] e_idx,
                       input logic e_last,
                       input string tag);
    chk({tag, "_valid"}, ov6, 1'b1);
    chk({tag, "_idx"}, idx6, e_idx);
    chk({tag, "_last"}, lst6, e_last);
  endtask

  initial begin
    #2;
    chk("rst_valid", ov[0], 1'b0);
    chk("rst_ready", ir[0], 1'b1);
    chk("rst_idx", idx[0], 3'd0);
    chk("rst_last", lst[0], 1'b0);
    chk("rst_none", non[0], 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // 1: MODE0 A4 -> 7,5,2 ; MODE1 -> 2,5,7
    accept(8'b1010_0100);
    beat(0, 3'd7, 1'b0, "t1_a");
    beat(1, 3'd2, 1'b0, "t1m1_a");
    step();
    beat(0, 3'd5, 1'b0, "t1_b");
    beat(1, 3'd5, 1'b0, "t1m1_b");
    step();
    beat(0, 3'd2, 1'b1, "t1_c");
    beat(1, 3'd7, 1'b1, "t1m1_c");
    step();
    chk("t1_ready_after", ir[0], 1'b1);
    chk("t1_valid_after", ov[0], 1'b0);

    // 2: one-hot walk then zero vector
    for (int i = 0; i < 8; i++) begin
      accept(8'h01 << i);
      beat(0, 3'(i), 1'b1, "t2_m0");
      beat(1, 3'(i), 1'b1, "t2_m1");
      step();
      chk("t2_ready", ir[0], 1'b1);
    end
    accept(8'h00);
    chk("t2z_valid", ov[0], 1'b1);
    chk("t2z_none", non[0], 1'b1);
    chk("t2z_last", lst[0], 1'b1);
    chk("t2z_idx", idx[0], 3'd0);
    chk("t2z_none_m2", non[2], 1'b1);
    step();
    chk("t2z_done", ov[0], 1'b0);

    // 3: stall holds beat stable
    out_ready = 1'b0;
    accept(8'hC0);
    for (int c = 0; c < 3; c++) begin
      chk("t3_stall_valid", ov[0], 1'b1);
      chk("t3_stall_idx", idx[0], 3'd7);
      chk("t3_stall_m1", idx[1], 3'd6);
      step();
    end
    out_ready = 1'b1;
    beat(0, 3'd7, 1'b0, "t3_a");
    step();
    beat(0, 3'd6, 1'b1, "t3_b");
    step();

    // 4: MODE1 81 -> 0,7 ; MODE0 -> 7,0
    accept(8'b1000_0001);
    beat(1, 3'd0, 1'b0, "t4_m1_a");
    beat(0, 3'd7, 1'b0, "t4_m0_a");
    step();
    beat(1, 3'd7, 1'b1, "t4_m1_b");
    beat(0, 3'd0, 1'b1, "t4_m0_b");
    step();

    // 5: round-robin from known ptr=0
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    accept(8'b0000_0010);
    beat(2, 3'd1, 1'b1, "t5_a");
    step();
    accept(8'b0100_0001);
    beat(2, 3'd6, 1'b0, "t5_b");
    beat(0, 3'd6, 1'b0, "t5_m0_b");
    beat(1, 3'd0, 1'b0, "t5_m1_b");
    step();
    beat(2, 3'd0, 1'b1, "t5_c");
    step();

    accept6(6'b10_0001);
    beat6(3'd0, 1'b0, "t5n6_a");
    step();
    beat6(3'd5, 1'b1, "t5n6_b");
    step();
    accept6(6'b10_0001);
    beat6(3'd0, 1'b0, "t5n6_wrap");
    step();
    beat6(3'd5, 1'b1, "t5n6_d");
    step();

    // 6: ptr=1 now; reset mid-vector
    accept(8'hFF);
    beat(2, 3'd1, 1'b0, "t6_a");
    step();
    beat(2, 3'd2, 1'b0, "t6_b");
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ov[2], 1'b0);
    chk("t6_rst_ready", ir[2], 1'b1);
    chk("t6_rst_idx", idx[2], 3'd0);
    chk("t6_rst_last", lst[2], 1'b0);
    in_valid = 1'b1;
    in_vec   = 8'hFF;
    step();
    chk("t6_rst_ignore", ov[2], 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("t6_rel_ready", ir[2], 1'b1);
    chk("t6_rel_valid", ov[2], 1'b0);
    accept(8'hFF);
    beat(2, 3'd0, 1'b0, "t6_first");
    for (int k = 1; k < 8; k++) begin
      step();
      beat(2, 3'(k), k == 7, "t6_drain");
    end
    step();
    chk("t6_end_ready", ir[2], 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
